// File: rtl/rr_arbiter_n_if.sv
// rtl/rr_arbiter_n_if.sv - requester-side bundle for the N-way round-robin arbiter
interface rr_arbiter_n_if #(
    parameter int N = 8
);
    localparam int PTR_W = $clog2(N);

    // Arbitration request side.
    logic             go;
    logic             mode;
    logic [N-1:0]     req;
    // Owner frees the resource; "release" itself is a reserved word.
    logic             release_i;

    // Grant side, all registered inside the arbiter.
    logic [N-1:0]     grant;
    logic [PTR_W-1:0] grant_id;
    logic             busy;
    logic [PTR_W-1:0] ptr;
    logic             go_dropped;

    modport master (
        output go, mode, req, release_i,
        input  grant, grant_id, busy, ptr, go_dropped
    );

    modport slave (
        input  go, mode, req, release_i,
        output grant, grant_id, busy, ptr, go_dropped
    );
endinterface

// File: rtl/rr_arbiter_n.sv
// rtl/rr_arbiter_n.sv - N-way round-robin arbiter with slot and work-conserving modes; optional SVA under RR_ARB_ASSERT_EN
module rr_arbiter_n #(
    parameter int N = 8
) (
    input logic           clk,
    input logic           reset_n,
    rr_arbiter_n_if.slave bus
);
    localparam int PTR_W = $clog2(N);
    localparam logic [N-1:0] ONE_HOT_0 = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             go_q, go_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [PTR_W-1:0] grant_id_q, grant_id_d;
    logic             go_dropped_q, go_dropped_d;

    logic             go_event;
    logic             arb_en;
    logic             wc_found;
    logic [PTR_W-1:0] wc_win;

    // Index arithmetic stays mod N so non-power-of-2 N never leaves 0..N-1.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        if (int'(p) >= N - 1) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) begin
            s = s - N;
        end
        return PTR_W'(s);
    endfunction

    // An event is a rising edge of go; arbitration only when idle and not releasing.
    assign go_event = bus.go && !go_q;
    assign arb_en   = go_event && (state_q == IDLE) && !bus.release_i;

    // Work-conserving winner: first requester at or after ptr, circularly.
    always_comb begin
        wc_found = 1'b0;
        wc_win   = '0;
        for (int k = 0; k < N; k++) begin
            if (!wc_found && bus.req[wrap_add(ptr_q, k)]) begin
                wc_found = 1'b1;
                wc_win   = wrap_add(ptr_q, k);
            end
        end
    end

    // Next-state: arbitration in IDLE, hold/release in HELD, drop reporting.
    always_comb begin
        state_d      = state_q;
        go_d         = bus.go;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        grant_id_d   = grant_id_q;
        go_dropped_d = 1'b0;

        if (go_event && ((state_q == HELD) || bus.release_i)) begin
            go_dropped_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (arb_en) begin
                    if (!bus.mode) begin
                        // Slot mode: the slot advances whether or not it is used.
                        ptr_d = wrap_inc(ptr_q);
                        if (bus.req[ptr_q]) begin
                            grant_d    = ONE_HOT_0 << ptr_q;
                            grant_id_d = ptr_q;
                            state_d    = HELD;
                        end
                    end else if (wc_found) begin
                        // Work-conserving: pointer moves just past the winner.
                        ptr_d      = wrap_inc(wc_win);
                        grant_d    = ONE_HOT_0 << wc_win;
                        grant_id_d = wc_win;
                        state_d    = HELD;
                    end
                end
            end
            HELD: begin
                if (bus.release_i) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    grant_id_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; go_q resets high so go must be seen low before the first event.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            go_q         <= 1'b1;
            ptr_q        <= '0;
            grant_q      <= '0;
            grant_id_q   <= '0;
            go_dropped_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            go_q         <= go_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            grant_id_q   <= grant_id_d;
            go_dropped_q <= go_dropped_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.busy       = (state_q == HELD);
    assign bus.ptr        = ptr_q;
    assign bus.go_dropped = go_dropped_q;

`ifdef RR_ARB_ASSERT_EN
    logic [N-1:0] wc_between;

    function automatic int wrap_dist(input int from, input int to);
        return (to - from + N) % N;
    endfunction

    // Requesters strictly between ptr and the work-conserving winner.
    always_comb begin
        wc_between = '0;
        for (int i = 0; i < N; i++) begin
            if (wrap_dist(int'(ptr_q), i) < wrap_dist(int'(ptr_q), int'(wc_win))) begin
                wc_between[i] = 1'b1;
            end
        end
    end

    a_grant_onehot0: assert property (@(posedge clk) $onehot0(grant_q));

    a_grant_stable: assert property (@(posedge clk)
        (reset_n && (state_q == HELD) && !bus.release_i) |=> $stable(grant_q));

    a_slot_ptr: assert property (@(posedge clk) disable iff (!reset_n)
        (arb_en && !bus.mode) |=> ((state_q != HELD) || (grant_id_q == $past(ptr_q))));

    a_wc_no_skip: assert property (@(posedge clk) disable iff (!reset_n)
        (arb_en && bus.mode && wc_found) |-> ((bus.req & wc_between) == '0));

    a_ptr_range: assert property (@(posedge clk) int'(ptr_q) < N);

    a_drop_cause: assert property (@(posedge clk) disable iff (!reset_n)
        go_dropped_q |-> $past((state_q == HELD) || bus.release_i));
`else
    // Checks compiled out; behaviour is unchanged.
`endif
endmodule

// File: doc/rr_arbiter_n.md
# rr_arbiter_n

Parametrised round-robin arbiter granting one of N requesters per rising edge of `go`. It supports two modes. Slot mode gives a strict rotating slot with no skip. Work-conserving mode grants the next active requester. A grant is held until the owner releases it. The block sits between N bus masters and a shared resource, and replaces the fixed 8-way rotating-slot scheme used so far.

## Interface
- `N`, 8, number of requesters; legal range 2..32.
- `PTR_W`, `$clog2(N)`, derived localparam; width of the pointer and `grant_id`.
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `go`  in  1  arbitration trigger; an event is a rising edge of `go`.
- `mode`  in  1  0 = slot mode, 1 = work-conserving mode; sampled only at an event.
- `req`  in  N  request vector; bit i belongs to requester i.
- `release`  in  1  the current owner frees the resource.
- `grant`  out  N  registered one-hot grant, or all zeros.
- `grant_id`  out  PTR_W  index of the granted requester; valid while `busy`.
- `busy`  out  1  a grant is currently held.
- `ptr`  out  PTR_W  next-candidate pointer, exposed for checkers.
- `go_dropped`  out  1  one-cycle pulse when an event is ignored.

## Operation
- Event detection:
  - `go_q` is `go` registered; event = `go && !go_q`.
  - `go_q` resets to 1, so `go` must be seen low after reset before the first event can occur.
- Arbitration runs at an event only when `busy`=0.
- Slot mode (`mode`=0):
  - If `req[ptr]`=1: grant `ptr`.
  - In all cases `ptr` <= (`ptr`+1) mod N.
  - If `req[ptr]`=0: no grant, `busy` stays 0.
- Work-conserving mode (`mode`=1):
  - Winner w = first index with `req` set, searching `ptr`, `ptr`+1, … mod N.
  - On a win: grant w and set `ptr` <= (w+1) mod N.
  - If `req`=0: no grant and `ptr` is unchanged.
- On a grant: `grant`=1<<w, `grant_id`=w, `busy`=1.
- Hold: `grant` stays stable while `busy`=1, regardless of `req` or `mode`.
- Release: `release`=1 while `busy` clears `grant`, `grant_id` and `busy` at that edge. `release` while idle is ignored.
- Event while `busy`, or coincident with `release`: no arbitration, `ptr` unchanged, `go_dropped`=1 for one cycle.
- Pointer wrap: arithmetic is mod N, so non-power-of-2 N never reaches index ≥N. With N=6, `ptr`=5 advances to 0.
- States: IDLE (`busy`=0) and HELD (`busy`=1).
  - IDLE→HELD on an event with a winner.
  - HELD→IDLE on `release`.
  - Any state→IDLE on reset.

## Timing
- Reset values: `grant`=0, `grant_id`=0, `busy`=0, `ptr`=0, `go_dropped`=0, `go_q`=1.
- Reset mid-grant aborts the grant at the same edge; there is no release handshake.
- Latency: `req` and `mode` are sampled at the edge where the event is detected. `grant`, `busy` and `ptr` update at that same edge and are visible the following cycle.
- `go` must be low for at least one cycle between events. Holding `go` high produces exactly one event.
- Minimum grant length is one cycle: `release` may be asserted the cycle after `busy` rises.
- All outputs come directly from flops; there are no combinational paths from inputs to outputs.

## Configuration
- `RR_ARB_ASSERT_EN`: when defined, the block compiles in concurrent SVA checks:
  - `grant` is onehot0.
  - `grant` is stable while `busy` && !`release`.
  - In slot mode, a grant can only go to the pre-event `ptr`.
  - In work-conserving mode, no requester between `ptr` and w was requesting.
  - `ptr` < N at all times.
  - `go_dropped` implies a prior-cycle `busy` or `release`.
- When not defined, no assertion code is compiled and functional behaviour is identical.

## Test plan
- Reset, then slot mode with `req`=8'hFF, eight events with a `release` after each → grants 0,1,…,7, then 0 again; `ptr` wraps 7→0.
- Slot mode, `ptr`=2, `req`=8'h08, event → no grant, `busy`=0, `ptr`=3; next event → grant=8'h08, `ptr`=4.
- Work-conserving mode, `ptr`=6, `req`=8'h05, event → `grant_id`=0, `ptr`=1; after release, next event → `grant_id`=2, `ptr`=3.
- Grant held to requester 1, event without release → `go_dropped` pulse, `grant` unchanged; event coincident with `release` → grant cleared, `go_dropped`=1, `ptr` unchanged.
- Reset asserted while `busy`=1 with `go` held high → all outputs at reset values next cycle; no event until `go` falls and rises again.
- N=6, work-conserving mode, `req`=6'b100000, `ptr`=0, event → `grant_id`=5, `ptr`=0; run all tests with `RR_ARB_ASSERT_EN` defined and expect zero assertion failures.
